ins_mem_loader: RTL and testbench
=================================

INS_MEM_LOADER -- requirements
Module: ins_mem_loader

Interface
REQ-001 The block SHALL have a parameter ADDR_WIDTH, default 8, giving the instruction memory address width.
REQ-002 The block SHALL have a parameter INS_WIDTH, default 9, giving the instruction width; legal range 9..16.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-004 The block SHALL have port clk, input, width 1: rising-edge clock for all state.
REQ-005 The block SHALL have port rst, input, width 1: synchronous, active-high reset.
REQ-006 The block SHALL have port start, input, width 1: one-cycle pulse that begins a load.
REQ-007 The block SHALL have port rx_data, input, width 8: incoming byte stream.
REQ-008 The block SHALL have port rx_valid, input, width 1: rx_data holds a byte.
REQ-009 The block SHALL have port rx_ready, output, width 1: a byte is consumed in any cycle where rx_valid and rx_ready are both high.
REQ-010 The block SHALL have port wEn, output, width 1: memory write strobe.
REQ-011 The block SHALL have port address, output, width ADDR_WIDTH: memory write address.
REQ-012 The block SHALL have port instruction, output, width INS_WIDTH: memory write data.
REQ-013 The block SHALL have port busy, output, width 1: a load is in progress; cores are held off the instruction memory.
REQ-014 The block SHALL have port done, output, width 1: the last load completed and is sticky until the next start or rst.

Function
REQ-015 The state machine SHALL have the states IDLE, LEN, LO, HI, WRITE and DONE.
REQ-016 IDLE and DONE: rx_ready=0 and busy=0; start moves to LEN and clears done.
REQ-017 LEN: rx_ready=1; on a byte handshake, word count N is latched as rx_data, with 0 meaning 2**ADDR_WIDTH (clamped to 2**ADDR_WIDTH when ADDR_WIDTH<8); address is cleared to 0; the next state is LO.
REQ-018 LO: rx_ready=1; on a handshake, rx_data is latched as instruction bits [7:0]; the next state is HI.
REQ-019 HI: rx_ready=1; on a handshake, rx_data[INS_WIDTH-9:0] is latched as instruction bits [INS_WIDTH-1:8]; the remaining high bits are ignored; the next state is WRITE.
REQ-020 WRITE: rx_ready=0 and wEn=1 for exactly one cycle, with address and instruction stable during that cycle.
REQ-021 Leaving WRITE: if the written address equals N-1, the next state is DONE and done=1; otherwise address increments by 1 and the next state is LO.
REQ-022 busy SHALL be 1 in LEN, LO, HI and WRITE, and 0 otherwise.
REQ-023 Throughput: one instruction per 3 cycles when rx_valid is held high, i.e. LO, HI and WRITE.
REQ-024 rx_valid low in LEN, LO or HI SHALL stall the state machine indefinitely with no timeout.
REQ-025 start SHALL be ignored while busy=1.
REQ-026 A start in DONE SHALL restart the load at LEN.
REQ-027 Bytes offered in IDLE or DONE SHALL not be consumed (rx_ready=0).
REQ-028 address SHALL never exceed N-1, and the address counter SHALL never wrap during a load.
REQ-029 wEn SHALL only assert in WRITE.

Reset
REQ-030 rst=1 SHALL force IDLE, with wEn=0, rx_ready=0, busy=0, done=0, address=0 and instruction=0 on the next edge.
REQ-031 rst SHALL have priority over start and rx_valid.
REQ-032 rst mid-load SHALL abort without a further write, leaving partially written memory untouched.

Verification
REQ-033 The bench SHALL cover: rst, start, then bytes 03, 12,01, 34,00, FF,FF with rx_valid held high -> wEn at addresses 0,1,2 with data 0x112, 0x034, 0x1FF; writes 3 cycles apart; done=1; busy=0.
REQ-034 The bench SHALL cover: length byte 00 with ADDR_WIDTH=8 -> exactly 256 writes at addresses 0..255, no wrap, then done=1.
REQ-035 The bench SHALL cover: rx_valid deasserted for 5 cycles between LO and HI -> no wEn and no state change during the gap; the write resumes with the correct data.
REQ-036 The bench SHALL cover: start pulsed during a load -> ignored, with the address sequence unchanged.
REQ-037 The bench SHALL cover: rst asserted after the LO byte of word 1 -> next cycle busy=0, done=0, rx_ready=0, and no write for word 1.
REQ-038 The bench SHALL cover: bytes offered in DONE -> rx_ready=0 with no writes; a new start with length 01, AA, 01 -> one write of 0x1AA at address 0.

Source files
------------

// File: rtl/ins_mem_loader_if.sv
// ins_mem_loader_if: start/byte-stream handshake and instruction-memory write bus; master drives start/rx_*, slave (loader) drives the rest
interface ins_mem_loader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int INS_WIDTH  = 9
);
  logic                  start;
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  wEn;
  logic [ADDR_WIDTH-1:0] address;
  logic [INS_WIDTH-1:0]  instruction;
  logic                  busy;
  logic                  done;
  modport master (
    output start, rx_data, rx_valid,
    input  rx_ready, wEn, address, instruction, busy, done
  );
  modport slave (
    input  start, rx_data, rx_valid,
    output rx_ready, wEn, address, instruction, busy, done
  );
endinterface

// File: rtl/ins_mem_loader.sv
// ins_mem_loader: loads N instructions (length byte, then lo/hi bytes per word) from a byte stream into instruction memory; ports clk, rst, bus (slave: start/rx_* in, rx_ready/wEn/address/instruction/busy/done out)
module ins_mem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int INS_WIDTH  = 9
) (
  input logic            clk,
  input logic            rst,
  ins_mem_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LEN, LO, HI, WRITE, DONE} state_t;
  localparam longint CAP = longint'(1) << ADDR_WIDTH;
  state_t                state_q;
  logic                  rx_ready_q, wen_q, busy_q, done_q;
  logic [ADDR_WIDTH-1:0] addr_q, last_q, last_d;
  logic [INS_WIDTH-1:0]  ins_q;
  logic [8:0]            len;
  logic                  hs;
  assign hs     = bus.rx_valid && rx_ready_q;
  // Length 0 means a full memory; narrow memories clamp the count to their size.
  assign len    = bus.rx_data == 8'd0 ? 9'd256 : {1'b0, bus.rx_data};
  assign last_d = ADDR_WIDTH'((longint'(len) > CAP ? CAP : longint'(len)) - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rx_ready_q <= 1'b0;
      wen_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      addr_q     <= '0;
      last_q     <= '0;
      ins_q      <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: if (bus.start) begin
          state_q    <= LEN;
          rx_ready_q <= 1'b1;
          busy_q     <= 1'b1;
          done_q     <= 1'b0;
        end
        LEN: if (hs) begin
          last_q  <= last_d;
          addr_q  <= '0;
          state_q <= LO;
        end
        LO: if (hs) begin
          ins_q[7:0] <= bus.rx_data;
          state_q    <= HI;
        end
        HI: if (hs) begin
          ins_q[INS_WIDTH-1:8] <= bus.rx_data[INS_WIDTH-9:0];
          rx_ready_q           <= 1'b0;
          wen_q                <= 1'b1;
          state_q              <= WRITE;
        end
        WRITE: begin
          wen_q <= 1'b0;
          if (addr_q == last_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            addr_q     <= addr_q + 1'b1;
            rx_ready_q <= 1'b1;
            state_q    <= LO;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.rx_ready    = rx_ready_q;
  assign bus.wEn         = wen_q;
  assign bus.address     = addr_q;
  assign bus.instruction = ins_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_ins_mem_loader.sv
// tb_ins_mem_loader: scoreboard bench for ins_mem_loader with directed byte streams
module tb_ins_mem_loader;
  localparam int AW = 8;
  localparam int IW = 9;
  typedef struct {
    logic [AW-1:0] a;
    logic [IW-1:0] d;
    int            gap;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ins_mem_loader_if #(.ADDR_WIDTH(AW), .INS_WIDTH(IW)) bus ();
  ins_mem_loader #(.ADDR_WIDTH(AW), .INS_WIDTH(IW)) dut (.clk(clk), .rst(rst), .bus(bus));
  exp_t sb[$];
  exp_t e;
  int vectors = 0, errs = 0, cyc = 0, last_wr = 0;
  logic [7:0] b;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask
  task automatic fail_now(input string name);
    vectors++;
    errs++;
    $display("FAIL %s: bound expired", name);
  endtask
  task automatic push(input logic [AW-1:0] a, input logic [IW-1:0] d, input int g);
    exp_t x;
    x.a = a;
    x.d = d;
    x.gap = g;
    sb.push_back(x);
  endtask
  always @(negedge clk) begin
    if (bus.wEn === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        errs++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, want no write", bus.address, bus.instruction);
      end else begin
        e = sb.pop_front();
        check("wr_addr", 32'(bus.address), 32'(e.a));
        check("wr_data", 32'(bus.instruction), 32'(e.d));
        if (e.gap != 0) check("wr_gap", cyc - last_wr, e.gap);
      end
      last_wr = cyc;
    end
  end
  task automatic send(input logic [7:0] v);
    int t = 0;
    bus.rx_data  = v;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    while (!bus.rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.rx_ready) fail_now("send_timeout");
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask
  task automatic wait_done();
    int t = 0;
    bus.rx_valid = 1'b0;
    @(negedge clk);
    while (!bus.done && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("done", 32'(bus.done), 1);
    check("busy_after", 32'(bus.busy), 0);
    check("sb_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.start = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_wEn", 32'(bus.wEn), 0);
    check("rst_rx_ready", 32'(bus.rx_ready), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_address", 32'(bus.address), 0);
    check("rst_instruction", 32'(bus.instruction), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    // three words, rx_valid held high
    push(8'd0, 9'h112, 0);
    push(8'd1, 9'h034, 3);
    push(8'd2, 9'h1FF, 3);
    pulse_start();
    check("busy_loading", 32'(bus.busy), 1);
    send(8'h03); send(8'h12); send(8'h01); send(8'h34); send(8'h00); send(8'hFF); send(8'hFF);
    wait_done();
    // bytes offered in DONE are not consumed, then restart
    bus.rx_data = 8'h55;
    bus.rx_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("rx_ready_in_done", 32'(bus.rx_ready), 0);
    end
    check("done_sticky", 32'(bus.done), 1);
    @(posedge clk);
    #1;
    push(8'd0, 9'h1AA, 0);
    pulse_start();
    check("done_cleared", 32'(bus.done), 0);
    send(8'h01); send(8'hAA); send(8'h01);
    wait_done();
    // stall between LO and HI with an ignored start in the gap
    push(8'd0, 9'h178, 0);
    push(8'd1, 9'h09A, 3);
    pulse_start();
    send(8'h02); send(8'h78);
    bus.rx_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.start = (i == 2);
      @(negedge clk);
      check("stall_busy", 32'(bus.busy), 1);
      check("stall_rx_ready", 32'(bus.rx_ready), 1);
      check("stall_address", 32'(bus.address), 0);
      check("stall_ins_lo", 32'(bus.instruction[7:0]), 32'h78);
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    send(8'h01); send(8'h9A); send(8'h00);
    wait_done();
    // full 256-word load; upper bits of each hi byte must be ignored
    pulse_start();
    send(8'h00);
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      push(b, {b[1], b}, i == 0 ? 0 : 3);
      send(b);
      send({7'b1010101, b[1]});
    end
    wait_done();
    check("final_address", 32'(bus.address), 255);
    // reset after the LO byte of word 1 aborts without writing word 1
    push(8'd0, 9'h011, 0);
    pulse_start();
    send(8'h03); send(8'h11); send(8'h00); send(8'h22);
    bus.rx_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_done", 32'(bus.done), 0);
    check("abort_rx_ready", 32'(bus.rx_ready), 0);
    check("abort_wEn", 32'(bus.wEn), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_sb_empty", sb.size(), 0);
    check("abort_idle_busy", 32'(bus.busy), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
